// File: rtl/ring_pkg.sv
// Shared types and defaults for the ring-counter decoder.
package ring_pkg;

   // Default ring length (number of one-hot bits).
   localparam int unsigned RING_WIDTH_DEF = 3;

   // Tracking states of the decoder.
   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      FAULT  = 2'd2
   } state_t;

endpackage : ring_pkg

// File: rtl/ring_onehot_dec.sv
// Combinational one-hot to binary decoder with a legality flag.
module ring_onehot_dec
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH = RING_WIDTH_DEF,
   parameter int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] ring_in,
   output logic [IDXW-1:0]  idx,
   output logic             is_onehot
);

   // OR of set-bit positions gives the index whenever exactly one bit is set;
   // zero is rejected explicitly, multiple set bits are caught by x & (x-1).
   always_comb begin
      idx       = '0;
      is_onehot = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) begin
            idx = idx | IDXW'(i);
         end
      end
   end

endmodule : ring_onehot_dec

// File: rtl/ring_decoder.sv
// Ring-counter sample tracker: decodes the hot-bit position, checks the
// rotate-left sequence, counts revolutions and latches sticky error flags.
module ring_decoder
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH = RING_WIDTH_DEF,
   parameter int unsigned IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ring_in,
   input  logic             in_valid,
   input  logic             clr_err,
   output logic [IDXW-1:0]  idx,
   output logic             idx_valid,
   output logic [7:0]       lap_count,
   output logic             locked,
   output logic             err_onehot,
   output logic             err_seq
);

   state_t           state, state_n;
   logic [WIDTH-1:0] prev, prev_n;
   logic [IDXW-1:0]  idx_n;
   logic             idx_valid_n;
   logic [7:0]       lap_n;
   logic             err_onehot_n, err_seq_n;
   logic [IDXW-1:0]  dec_idx;
   logic             dec_onehot;
   logic [WIDTH-1:0] succ;

   ring_onehot_dec #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_dec (
      .ring_in   (ring_in),
      .idx       (dec_idx),
      .is_onehot (dec_onehot)
   );

   assign succ = {prev[WIDTH-2:0], prev[WIDTH-1]};

   // Register all state and outputs; locked is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SEARCH;
         prev       <= '0;
         idx        <= '0;
         idx_valid  <= 1'b0;
         lap_count  <= '0;
         locked     <= 1'b0;
         err_onehot <= 1'b0;
         err_seq    <= 1'b0;
      end else begin
         state      <= state_n;
         prev       <= prev_n;
         idx        <= idx_n;
         idx_valid  <= idx_valid_n;
         lap_count  <= lap_n;
         locked     <= (state_n == TRACK);
         err_onehot <= err_onehot_n;
         err_seq    <= err_seq_n;
      end
   end

   // Next-state and output logic; the clear is applied first so that an error
   // detected in the same cycle overrides it.
   always_comb begin
      state_n      = state;
      prev_n       = prev;
      idx_n        = idx;
      idx_valid_n  = 1'b0;
      lap_n        = lap_count;
      err_onehot_n = err_onehot;
      err_seq_n    = err_seq;

      if (clr_err) begin
         err_onehot_n = 1'b0;
         err_seq_n    = 1'b0;
      end

      case (state)
         SEARCH: begin
            if (in_valid) begin
               if (dec_onehot) begin
                  prev_n      = ring_in;
                  idx_n       = dec_idx;
                  idx_valid_n = 1'b1;
                  state_n     = TRACK;
               end else begin
                  err_onehot_n = 1'b1;
               end
            end
         end
         TRACK: begin
            if (in_valid) begin
               if (!dec_onehot) begin
                  err_onehot_n = 1'b1;
                  state_n      = FAULT;
               end else if (ring_in == succ) begin
                  prev_n      = ring_in;
                  idx_n       = dec_idx;
                  idx_valid_n = 1'b1;
                  if (ring_in[0] && prev[WIDTH-1]) begin
                     lap_n = lap_count + 8'd1;
                  end
               end else begin
                  err_seq_n = 1'b1;
                  state_n   = FAULT;
               end
            end
         end
         FAULT: begin
            if (clr_err) begin
               state_n = SEARCH;
            end
         end
         default: begin
            state_n = SEARCH;
         end
      endcase
   end

endmodule : ring_decoder
